// File: rtl/camera_packet_reader.sv
// camera_packet_reader
// Pops bytes from the camera byte FIFO and frames them into packets of the form
// SYNC_BYTE, length, payload[length], XOR checksum. Payload bytes are packed
// big-endian into 16-bit pixel words on a valid/ready stream. Each complete
// packet produces a one-cycle pkt_done (checksum good) or pkt_err (bad checksum
// or illegal length) pulse.
//
// Optional build macro CAMERA_PKT_STATS_EN adds saturating good_cnt / bad_cnt
// packet counters as extra output ports. Without the macro those ports and
// counters do not exist and the block behaves identically otherwise.
//
// DATO_WIDTH must stay 8; the framing logic is byte oriented.

module camera_packet_reader #(
    parameter int         DATO_WIDTH = 8,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         MAX_LEN    = 52
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empy,
    output logic                  fifo_rd,
    input  logic [DATO_WIDTH-1:0] fifo_data,
    output logic [15:0]           pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_last,
    output logic                  pkt_done,
    output logic                  pkt_err
`ifdef CAMERA_PKT_STATS_EN
    ,
    output logic [15:0]           good_cnt,
    output logic [15:0]           bad_cnt
`endif
);

    // Remaining-byte counter only has to hold 0..MAX_LEN.
    localparam int               REM_W     = $clog2(MAX_LEN + 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [REM_W-1:0] REM_ONE   = REM_W'(1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CHECK   = 2'd3
    } state_t;

    state_t           state_reg;
    logic             run_reg;         // low during and just after reset, gates reads
    logic             rd_pending_reg;  // a read was issued last cycle; data is on fifo_data now
    logic [7:0]       csum_reg;
    logic [REM_W-1:0] remaining_reg;
    logic             odd_reg;         // next payload byte is the low half of a word
    logic [7:0]       hi_reg;
    logic [15:0]      pix_data_reg;
    logic             pix_valid_reg;
    logic             pix_last_reg;
    logic             pkt_done_reg;
    logic             pkt_err_reg;

    logic [7:0]       rd_byte;
    logic             byte_vld;
    logic             pix_accept;
    logic             len_ok;
    logic             final_byte;

    assign rd_byte    = fifo_data[7:0];
    assign byte_vld   = rd_pending_reg;
    assign pix_accept = pix_valid_reg && pix_ready;
    assign len_ok     = (rd_byte != 8'h00) && (rd_byte <= MAX_LEN_B);
    assign final_byte = (remaining_reg == REM_ONE);

    // The read strobe looks at the live empty flag so it can never fire on an
    // empty FIFO. Only one read is ever in flight, and while a word is waiting
    // in PAYLOAD no further payload byte is fetched, so the holding register
    // can never be overwritten. CHECK, HUNT and LEN may keep reading while a
    // word is stalled.
    assign fifo_rd = run_reg && !fifo_empy && !rd_pending_reg &&
                     ((state_reg != PAYLOAD) || !pix_valid_reg);

    // Read pipeline: track the single outstanding read so its data is sampled
    // exactly one cycle after the strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_reg        <= 1'b0;
            rd_pending_reg <= 1'b0;
        end else begin
            run_reg        <= 1'b1;
            rd_pending_reg <= fifo_rd;
        end
    end

    // Packet framer: every state change happens on a byte sample cycle; the
    // pixel stream and the status pulses are registered here as well.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= HUNT;
            csum_reg      <= 8'h00;
            remaining_reg <= '0;
            odd_reg       <= 1'b0;
            hi_reg        <= 8'h00;
            pix_data_reg  <= 16'h0000;
            pix_valid_reg <= 1'b0;
            pix_last_reg  <= 1'b0;
            pkt_done_reg  <= 1'b0;
            pkt_err_reg   <= 1'b0;
        end else begin
            pkt_done_reg <= 1'b0;
            pkt_err_reg  <= 1'b0;

            // A word leaves on acceptance; pix_data is simply left as is.
            if (pix_accept) begin
                pix_valid_reg <= 1'b0;
                pix_last_reg  <= 1'b0;
            end

            if (byte_vld) begin
                case (state_reg)
                    HUNT: begin
                        // Anything other than the marker is dropped.
                        if (rd_byte == SYNC_BYTE) begin
                            state_reg <= LEN;
                        end
                    end

                    LEN: begin
                        if (len_ok) begin
                            // The checksum covers the length byte too.
                            csum_reg      <= rd_byte;
                            remaining_reg <= REM_W'(rd_byte);
                            odd_reg       <= 1'b0;
                            state_reg     <= PAYLOAD;
                        end else begin
                            pkt_err_reg <= 1'b1;
                            state_reg   <= HUNT;
                        end
                    end

                    PAYLOAD: begin
                        csum_reg      <= csum_reg ^ rd_byte;
                        remaining_reg <= remaining_reg - REM_ONE;
                        odd_reg       <= ~odd_reg;
                        if (!odd_reg) begin
                            hi_reg <= rd_byte;
                            // Odd length: the last byte travels alone, zero padded.
                            if (final_byte) begin
                                pix_data_reg  <= {rd_byte, 8'h00};
                                pix_valid_reg <= 1'b1;
                                pix_last_reg  <= 1'b1;
                            end
                        end else begin
                            pix_data_reg  <= {hi_reg, rd_byte};
                            pix_valid_reg <= 1'b1;
                            pix_last_reg  <= final_byte;
                        end
                        if (final_byte) begin
                            state_reg <= CHECK;
                        end
                    end

                    CHECK: begin
                        // Words have already gone out; the pulse tells the
                        // consumer whether to keep or discard them.
                        if (rd_byte == csum_reg) begin
                            pkt_done_reg <= 1'b1;
                        end else begin
                            pkt_err_reg <= 1'b1;
                        end
                        state_reg <= HUNT;
                    end

                    default: begin
                        state_reg <= HUNT;
                    end
                endcase
            end
        end
    end

    assign pix_data  = pix_data_reg;
    assign pix_valid = pix_valid_reg;
    assign pix_last  = pix_last_reg;
    assign pkt_done  = pkt_done_reg;
    assign pkt_err   = pkt_err_reg;

`ifdef CAMERA_PKT_STATS_EN
    // Lane 0 counts good packets, lane 1 counts failed ones.
    logic [1:0] stat_evt;
    assign stat_evt = {pkt_err_reg, pkt_done_reg};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stat
            logic [15:0] cnt_reg;

            // Saturating event counter: sticks at all-ones instead of wrapping.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg <= 16'h0000;
                end else if (stat_evt[gi] && (cnt_reg != 16'hFFFF)) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
        end
    endgenerate

    assign good_cnt = g_stat[0].cnt_reg;
    assign bad_cnt  = g_stat[1].cnt_reg;
`endif

endmodule

// File: tb/tb_camera_packet_reader.sv
// Bench for camera_packet_reader: a FIFO responder plus a packet-level
// reference model that turns a byte stream into expected pixel words and
// pass/fail events, compared against what the DUT streams out.

module tb_camera_packet_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fifo_empy;
    logic        fifo_rd;
    logic [7:0]  fifo_data = 8'h00;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        pix_last;
    logic        pkt_done;
    logic        pkt_err;
`ifdef CAMERA_PKT_STATS_EN
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // FIFO responder state
    logic [7:0] mem [0:4095];
    int         rd_ptr = 0;
    int         wr_ptr = 0;
    logic       fifo_hold = 1'b0;
    int         fifo_viol = 0;

    // Stream drive modes (written by tasks only)
    logic       rdy_rand  = 1'b0;
    logic       rdy_fix   = 1'b1;
    logic       hold_rand = 1'b0;

    // Monitor records
    logic [16:0] got_w[$];
    int          got_ev[$];
    int          mon_viol = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = 16'h0000;
    logic        prev_last = 1'b0;

    // Expectations
    logic [7:0]  stim[$];
    logic [16:0] exp_w[$];
    int          exp_ev[$];
    int          exp_good = 0;
    int          exp_bad  = 0;
    int          base_w = 0;
    int          base_ev = 0;

    always #5 clk = ~clk;

    assign fifo_empy = (rd_ptr == wr_ptr) || fifo_hold;

    camera_packet_reader dut (
        .clk       (clk),
        .reset     (reset),
        .fifo_empy (fifo_empy),
        .fifo_rd   (fifo_rd),
        .fifo_data (fifo_data),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_last  (pix_last),
        .pkt_done  (pkt_done),
        .pkt_err   (pkt_err)
`ifdef CAMERA_PKT_STATS_EN
        ,
        .good_cnt  (good_cnt),
        .bad_cnt   (bad_cnt)
`endif
    );

    // FIFO read port: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (fifo_rd) begin
            if (fifo_empy) begin
                fifo_viol <= fifo_viol + 1;
            end else begin
                fifo_data <= mem[rd_ptr[11:0]];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    // Drive pix_ready / FIFO stalls, then record handshakes and pulses.
    always @(negedge clk) begin
        if (rdy_rand) pix_ready = ($urandom_range(0, 3) != 0);
        else          pix_ready = rdy_fix;
        if (hold_rand) fifo_hold = ($urandom_range(0, 2) == 0);
        else           fifo_hold = 1'b0;
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!pix_valid || pix_data !== prev_data || pix_last !== prev_last))
                mon_viol++;
            if (pix_valid && pix_ready) got_w.push_back({pix_last, pix_data});
            if (pkt_done) got_ev.push_back(1);
            if (pkt_err)  got_ev.push_back(2);
            if (pkt_done && pkt_err) mon_viol++;
            prev_stall = pix_valid && !pix_ready;
            prev_data  = pix_data;
            prev_last  = pix_last;
        end
    end

    // Packet-level reference: parse stim as whole packets and append the
    // words and events they must produce.
    task automatic model_stim();
        int i = 0;
        int n = stim.size();
        int len;
        logic [7:0] x;
        logic [7:0] hi;
        logic [7:0] lo;
        logic lb;
        while (i < n) begin
            if (stim[i] != 8'hA5) begin
                i++;
                continue;
            end
            i++;
            if (i >= n) break;
            len = int'(stim[i]);
            i++;
            if (len == 0 || len > 52) begin
                exp_ev.push_back(2);
                exp_bad++;
                continue;
            end
            if (i + len >= n) break;
            x = 8'(len);
            for (int k = 0; k < len; k++) x = x ^ stim[i + k];
            for (int k = 0; k < len; k += 2) begin
                hi = stim[i + k];
                lo = (k + 1 < len) ? stim[i + k + 1] : 8'h00;
                lb = (k + 2 >= len);
                exp_w.push_back({lb, hi, lo});
            end
            if (stim[i + len] == x) begin
                exp_ev.push_back(1);
                exp_good++;
            end else begin
                exp_ev.push_back(2);
                exp_bad++;
            end
            i += len + 1;
        end
    endtask

    task automatic begin_case();
        base_w  = got_w.size();
        base_ev = got_ev.size();
        exp_w.delete();
        exp_ev.delete();
    endtask

    // Model the current stim and hand it to the FIFO.
    task automatic load_stim();
        model_stim();
        foreach (stim[j]) begin
            mem[wr_ptr[11:0]] = stim[j];
            wr_ptr++;
        end
    endtask

    task automatic wait_idle(input string name);
        int quiet = 0;
        for (int cyc = 0; cyc < 20000 && quiet < 4; cyc++) begin
            @(negedge clk);
            if (rd_ptr == wr_ptr && !pix_valid) quiet++;
            else quiet = 0;
        end
        total++;
        if (quiet < 4) begin
            bad++;
            $display("FAIL %s idle_timeout: quiet=%0d required=4", name, quiet);
        end
    endtask

    task automatic check_results(input string name);
        int nw = got_w.size() - base_w;
        int ne = got_ev.size() - base_ev;
        total++;
        if (nw != exp_w.size()) begin
            bad++;
            $display("FAIL %s word_count: got=%0d exp=%0d", name, nw, exp_w.size());
        end
        for (int i = 0; i < nw && i < exp_w.size(); i++) begin
            total++;
            if (got_w[base_w + i] !== exp_w[i]) begin
                bad++;
                $display("FAIL %s word[%0d]: got last=%0b data=%h exp last=%0b data=%h", name, i,
                         got_w[base_w + i][16], got_w[base_w + i][15:0], exp_w[i][16], exp_w[i][15:0]);
            end
        end
        total++;
        if (ne != exp_ev.size()) begin
            bad++;
            $display("FAIL %s event_count: got=%0d exp=%0d", name, ne, exp_ev.size());
        end
        for (int i = 0; i < ne && i < exp_ev.size(); i++) begin
            total++;
            if (got_ev[base_ev + i] != exp_ev[i]) begin
                bad++;
                $display("FAIL %s event[%0d]: got=%0d exp=%0d (1=done 2=err)", name, i,
                         got_ev[base_ev + i], exp_ev[i]);
            end
        end
        total++;
        if (mon_viol != 0) begin
            bad++;
            $display("FAIL %s stream_protocol: violations=%0d exp=0", name, mon_viol);
        end
        total++;
        if (fifo_viol != 0) begin
            bad++;
            $display("FAIL %s read_on_empty: count=%0d exp=0", name, fifo_viol);
        end
`ifdef CAMERA_PKT_STATS_EN
        total++;
        if (good_cnt !== 16'(exp_good)) begin
            bad++;
            $display("FAIL %s good_cnt: got=%0d exp=%0d", name, good_cnt, exp_good);
        end
        total++;
        if (bad_cnt !== 16'(exp_bad)) begin
            bad++;
            $display("FAIL %s bad_cnt: got=%0d exp=%0d", name, bad_cnt, exp_bad);
        end
`endif
        $display("case %s: words=%0d events=%0d", name, nw, ne);
    endtask

    // Append one random packet with up to two garbage bytes in front.
    // kind 0 = good, 1 = bad checksum, 2 = illegal length.
    task automatic gen_packet(input int kind);
        int ng = $urandom_range(0, 2);
        int len;
        int r;
        logic [7:0] b;
        logic [7:0] x;
        for (int g = 0; g < ng; g++) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hA5) b = 8'h5A;
            stim.push_back(b);
        end
        stim.push_back(8'hA5);
        if (kind == 2) begin
            if ($urandom_range(0, 1) == 0) stim.push_back(8'h00);
            else stim.push_back(8'($urandom_range(53, 255)));
            return;
        end
        r = $urandom_range(0, 9);
        if (r == 0)      len = 1;
        else if (r == 1) len = 52;
        else             len = $urandom_range(1, 52);
        stim.push_back(8'(len));
        x = 8'(len);
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom_range(0, 255));
            stim.push_back(b);
            x = x ^ b;
        end
        if (kind == 1) x = x ^ 8'($urandom_range(1, 255));
        stim.push_back(x);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        mem[wr_ptr[11:0]] = 8'h5A;
        wr_ptr++;
        repeat (3) @(negedge clk);
        total++; if (fifo_rd !== 1'b0) begin bad++; $display("FAIL reset fifo_rd: got=%b exp=0", fifo_rd); end
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL reset pix_valid: got=%b exp=0", pix_valid); end
        total++; if (pix_last !== 1'b0) begin bad++; $display("FAIL reset pix_last: got=%b exp=0", pix_last); end
        total++; if (pix_data !== 16'h0000) begin bad++; $display("FAIL reset pix_data: got=%h exp=0000", pix_data); end
        total++; if (pkt_done !== 1'b0) begin bad++; $display("FAIL reset pkt_done: got=%b exp=0", pkt_done); end
        total++; if (pkt_err !== 1'b0) begin bad++; $display("FAIL reset pkt_err: got=%b exp=0", pkt_err); end
`ifdef CAMERA_PKT_STATS_EN
        total++; if (good_cnt !== 16'h0 || bad_cnt !== 16'h0) begin
            bad++; $display("FAIL reset counters: got=%0d/%0d exp=0/0", good_cnt, bad_cnt); end
`endif
        wr_ptr = rd_ptr;
        reset = 1'b1;
        exp_good = 0;
        exp_bad  = 0;
        $display("case reset: done");
    endtask

    task automatic test_directed();
        rdy_rand = 1'b0; rdy_fix = 1'b1; hold_rand = 1'b0;
        begin_case();
        stim = '{8'hA5, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40};
        load_stim();
        stim = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h03};
        load_stim();
        stim = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h00};
        load_stim();
        wait_idle("directed_a");
        check_results("directed_a");
`ifdef CAMERA_PKT_STATS_EN
        total++;
        if (good_cnt !== 16'd2 || bad_cnt !== 16'd1) begin
            bad++;
            $display("FAIL directed_a stats: got good=%0d bad=%0d exp good=2 bad=1", good_cnt, bad_cnt);
        end
`endif
        begin_case();
        stim = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h7F};
        load_stim();
        stim = '{8'hA5, 8'h00, 8'hA5, 8'h35};
        load_stim();
        stim = '{8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h02};
        load_stim();
        wait_idle("directed_b");
        check_results("directed_b");
    endtask

    task automatic test_random();
        int kr;
        rdy_rand = 1'b1; hold_rand = 1'b1;
        for (int it = 0; it < 6; it++) begin
            begin_case();
            for (int p = 0; p < 5; p++) begin
                stim.delete();
                kr = $urandom_range(0, 9);
                gen_packet(kr < 6 ? 0 : (kr < 8 ? 1 : 2));
                load_stim();
            end
            wait_idle("random");
            check_results("random");
        end
        rdy_rand = 1'b0; hold_rand = 1'b0; rdy_fix = 1'b1;
    endtask

    task automatic test_back_to_back();
        rdy_rand = 1'b0; rdy_fix = 1'b1; hold_rand = 1'b0;
        begin_case();
        for (int p = 0; p < 8; p++) begin
            stim.delete();
            gen_packet(0);
            load_stim();
        end
        wait_idle("back_to_back");
        check_results("back_to_back");
    endtask

    task automatic test_stall_and_reset();
        int c;
        rdy_rand = 1'b0; hold_rand = 1'b0; rdy_fix = 1'b0;
        @(negedge clk);
        begin_case();
        stim = '{8'hA5, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40};
        load_stim();
        for (c = 0; c < 200; c++) begin
            @(negedge clk);
            if (pix_valid) break;
        end
        total++;
        if (!pix_valid || pix_data !== 16'h1122 || pix_last !== 1'b0) begin
            bad++;
            $display("FAIL stall first_word: got valid=%b data=%h last=%b exp valid=1 data=1122 last=0",
                     pix_valid, pix_data, pix_last);
        end
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            total++;
            if (pix_valid !== 1'b1 || pix_data !== 16'h1122 || fifo_rd !== 1'b0) begin
                bad++;
                $display("FAIL stall hold[%0d]: got valid=%b data=%h rd=%b exp valid=1 data=1122 rd=0",
                         s, pix_valid, pix_data, fifo_rd);
            end
        end
        rdy_fix = 1'b1;
        wait_idle("stall");
        check_results("stall");

        // Abort a packet mid-payload with an asynchronous reset.
        stim = '{8'hA5, 8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h01};
        foreach (stim[j]) begin
            mem[wr_ptr[11:0]] = stim[j];
            wr_ptr++;
        end
        for (c = 0; c < 200; c++) begin
            @(negedge clk);
            if (pix_valid) break;
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if (fifo_rd !== 1'b0 || pix_valid !== 1'b0 || pix_last !== 1'b0 || pix_data !== 16'h0000 ||
            pkt_done !== 1'b0 || pkt_err !== 1'b0) begin
            bad++;
            $display("FAIL async_reset outputs: got rd=%b valid=%b last=%b data=%h done=%b err=%b exp all 0",
                     fifo_rd, pix_valid, pix_last, pix_data, pkt_done, pkt_err);
        end
        wr_ptr = rd_ptr;
        exp_good = 0;
        exp_bad  = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        begin_case();
        stim = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h03};
        load_stim();
        wait_idle("after_reset");
        check_results("after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall_and_reset();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
